sqrt_bus_initiator: RTL and testbench

- Bus initiator (master) for the memory-mapped square-root peripheral's cs/addr/rd/wr/d_in/d_out register interface.
- Takes one operand per request over a valid/ready handshake and performs the full register sequence: write A, write INIT, poll DONE, read RESULT.
- Returns the result, or a timeout flag, on a valid/ready response channel.
- Sits between a sequencer/CPU-side command source and the peripheral, replacing hand-driven bus sequences.

---
 rtl/sqrt_periph_pkg.sv | 52 +++++
 rtl/bus_access_timer.sv | 34 +++
 rtl/sqrt_bus_initiator.sv | 253 +++++++++++++++++++++++++
 tb/tb_sqrt_bus_initiator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_periph_pkg.sv
// Shared definitions for the square-root peripheral register map and the
// bus initiator that drives it: register addresses, DONE bit position, the
// INIT start value, the initiator state encoding and small state decoders.
package sqrt_periph_pkg;

    // Register map of the square-root peripheral
    localparam logic [4:0]  REG_A_ADDR      = 5'h04;
    localparam logic [4:0]  REG_INIT_ADDR   = 5'h0C;
    localparam logic [4:0]  REG_RESULT_ADDR = 5'h10;
    localparam logic [4:0]  REG_DONE_ADDR   = 5'h14;

    // DONE register bit that signals a finished computation
    localparam int          DONE_BIT        = 0;

    // Value written to INIT to start a computation
    localparam logic [15:0] INIT_START      = 16'h0001;

    // Width of the shared gap / latency down-counter (covers POLL_GAP up to 255)
    localparam int          TMR_W           = 8;

    // Initiator sequence states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_A      = 4'd1,
        ST_GAP_A     = 4'd2,
        ST_WR_INIT   = 4'd3,
        ST_WAIT_POLL = 4'd4,
        ST_POLL      = 4'd5,
        ST_POLL_CAP  = 4'd6,
        ST_GAP_R     = 4'd7,
        ST_RD_RES    = 4'd8,
        ST_RES_CAP   = 4'd9,
        ST_RESP      = 4'd10
    } init_state_e;

    // States whose single cycle is a bus write strobe
    function automatic logic is_write_state(input init_state_e s);
        return (s == ST_WR_A) || (s == ST_WR_INIT);
    endfunction

    // States whose single cycle is a bus read strobe
    function automatic logic is_read_state(input init_state_e s);
        return (s == ST_POLL) || (s == ST_RD_RES);
    endfunction

    // States during which the INIT-to-DONE timeout counter advances
    function automatic logic is_timed_state(input init_state_e s);
        return (s == ST_WR_INIT) || (s == ST_WAIT_POLL) ||
               (s == ST_POLL)    || (s == ST_POLL_CAP);
    endfunction

endpackage

// File: rtl/bus_access_timer.sv
// Shared down-counter used for idle gaps, poll spacing and read latency.
// Loading N on the edge that enters a timed state makes 'expire' high in
// the N-th cycle spent in that state (N >= 1).
module bus_access_timer
    import sqrt_periph_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire
);

    logic [TMR_W-1:0] cnt_r;

    // Count register: load on state entry, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - TMR_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == TMR_W'(1));

endmodule

// File: rtl/sqrt_bus_initiator.sv
// Bus initiator for the square-root peripheral. Accepts one operand per
// request and runs the register sequence write A, write INIT, poll DONE,
// read RESULT, then presents the result (or a timeout) on the response
// channel. All outputs are registered from the next-state decode so the
// bus strobes line up exactly with the access states.
module sqrt_bus_initiator
    import sqrt_periph_pkg::*;
#(
    parameter logic [4:0] ADDR_A      = REG_A_ADDR,
    parameter logic [4:0] ADDR_INIT   = REG_INIT_ADDR,
    parameter logic [4:0] ADDR_RESULT = REG_RESULT_ADDR,
    parameter logic [4:0] ADDR_DONE   = REG_DONE_ADDR,
    parameter int         GAP         = 1,
    parameter int         POLL_GAP    = 4,
    parameter int         RD_LAT      = 1,
    parameter int         TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_operand,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_timeout,
    output logic        busy,
    output logic        bus_cs,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [4:0]  bus_addr,
    output logic [15:0] bus_dout,
    input  logic [31:0] bus_din
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    init_state_e      state_r;
    init_state_e      next_state_s;
    logic             tmr_load_s;
    logic [TMR_W-1:0] tmr_len_s;
    logic             tmr_expire_s;
    logic             tmr_srst_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic             timed_out_s;
    logic             done_s;
    logic             resp_entry_s;

    assign done_s       = bus_din[DONE_BIT];
    assign timed_out_s  = (to_cnt_r >= TO_W'(TIMEOUT));
    assign tmr_srst_s   = (state_r == ST_IDLE);
    assign resp_entry_s = (next_state_s == ST_RESP) && (state_r != ST_RESP);

    bus_access_timer u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (tmr_srst_s),
        .load     (tmr_load_s),
        .load_val (tmr_len_s),
        .expire   (tmr_expire_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and gap/latency timer loads on state entry
    always_comb begin
        next_state_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_len_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = ST_WR_A;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR_A: begin
                next_state_s = ST_GAP_A;
                tmr_load_s   = 1'b1;
                tmr_len_s    = TMR_W'(GAP);
            end
            ST_GAP_A: begin
                if (tmr_expire_s) begin
                    next_state_s = ST_WR_INIT;
                end else begin
                    next_state_s = ST_GAP_A;
                end
            end
            ST_WR_INIT: begin
                next_state_s = ST_WAIT_POLL;
                tmr_load_s   = 1'b1;
                tmr_len_s    = TMR_W'(POLL_GAP);
            end
            ST_WAIT_POLL: begin
                if (timed_out_s) begin
                    next_state_s = ST_RESP;
                end else if (tmr_expire_s) begin
                    next_state_s = ST_POLL;
                end else begin
                    next_state_s = ST_WAIT_POLL;
                end
            end
            ST_POLL: begin
                next_state_s = ST_POLL_CAP;
                tmr_load_s   = 1'b1;
                tmr_len_s    = TMR_W'(RD_LAT);
            end
            ST_POLL_CAP: begin
                // done seen on the sample cycle wins over a simultaneous timeout
                if (tmr_expire_s) begin
                    if (done_s) begin
                        next_state_s = ST_GAP_R;
                        tmr_load_s   = 1'b1;
                        tmr_len_s    = TMR_W'(GAP);
                    end else if (timed_out_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT_POLL;
                        tmr_load_s   = 1'b1;
                        tmr_len_s    = TMR_W'(POLL_GAP);
                    end
                end else begin
                    next_state_s = ST_POLL_CAP;
                end
            end
            ST_GAP_R: begin
                if (tmr_expire_s) begin
                    next_state_s = ST_RD_RES;
                end else begin
                    next_state_s = ST_GAP_R;
                end
            end
            ST_RD_RES: begin
                next_state_s = ST_RES_CAP;
                tmr_load_s   = 1'b1;
                tmr_len_s    = TMR_W'(RD_LAT);
            end
            ST_RES_CAP: begin
                if (tmr_expire_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_RES_CAP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // INIT-to-DONE timeout counter: zero in the WR_INIT cycle, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= '0;
        end else if ((next_state_s == ST_WR_INIT) && (state_r != ST_WR_INIT)) begin
            to_cnt_r <= '0;
        end else if (is_timed_state(state_r) && (to_cnt_r != '1)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Request/response handshake and busy flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            req_ready  <= (next_state_s == ST_IDLE);
            busy       <= (next_state_s != ST_IDLE);
            resp_valid <= (next_state_s == ST_RESP);
        end
    end

    // Bus strobes: high only for the single cycle of an access state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_cs <= 1'b0;
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
        end else begin
            bus_cs <= is_write_state(next_state_s) || is_read_state(next_state_s);
            bus_rd <= is_read_state(next_state_s);
            bus_wr <= is_write_state(next_state_s);
        end
    end

    // Bus address and write data; both hold their last value between accesses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_addr <= 5'h00;
            bus_dout <= 16'h0000;
        end else begin
            case (next_state_s)
                ST_WR_A: begin
                    bus_addr <= ADDR_A;
                    bus_dout <= req_operand;
                end
                ST_WR_INIT: begin
                    bus_addr <= ADDR_INIT;
                    bus_dout <= INIT_START;
                end
                ST_POLL: begin
                    bus_addr <= ADDR_DONE;
                    bus_dout <= bus_dout;
                end
                ST_RD_RES: begin
                    bus_addr <= ADDR_RESULT;
                    bus_dout <= bus_dout;
                end
                default: begin
                    bus_addr <= bus_addr;
                    bus_dout <= bus_dout;
                end
            endcase
        end
    end

    // Response payload: full RESULT capture, or zero with the timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_result  <= 32'h0000_0000;
            resp_timeout <= 1'b0;
        end else if (resp_entry_s && (state_r == ST_RES_CAP)) begin
            resp_result  <= bus_din;
            resp_timeout <= 1'b0;
        end else if (resp_entry_s) begin
            resp_result  <= 32'h0000_0000;
            resp_timeout <= 1'b1;
        end else begin
            resp_result  <= resp_result;
            resp_timeout <= resp_timeout;
        end
    end

endmodule

// File: tb/tb_sqrt_bus_initiator.sv
// Self-checking bench for sqrt_bus_initiator with a behavioural peripheral
// model (RD_LAT = 1, configurable DONE delay) and a response scoreboard.
module tb_sqrt_bus_initiator;
    import sqrt_periph_pkg::*;

    localparam int TB_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_operand;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_timeout;
    logic        busy;
    logic        bus_cs;
    logic        bus_rd;
    logic        bus_wr;
    logic [4:0]  bus_addr;
    logic [15:0] bus_dout;
    logic [31:0] bus_din = 32'h0;

    sqrt_bus_initiator #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_operand  (req_operand),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .bus_cs       (bus_cs),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_addr     (bus_addr),
        .bus_dout     (bus_dout),
        .bus_din      (bus_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    typedef struct packed {
        logic [31:0] result;
        logic        timeout;
    } resp_t;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } acc_t;

    resp_t exp_q[$];
    acc_t  log_q[$];
    int    resp_count  = 0;
    int    rv_rise_cyc = -1;
    int    proto_bad   = 0;
    bit    prev_rv     = 1'b0;
    int    cyc         = 0;

    // Peripheral model state
    logic [15:0] a_reg      = 16'h0;
    int          init_cyc   = 0;
    bit          started    = 1'b0;
    int          done_delay = -1;

    function automatic logic [31:0] isqrt(input logic [15:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return 32'(r);
    endfunction

    function automatic acc_t get_acc(input int i);
        acc_t a;
        a = '{cyc: -1, wr: 1'b0, addr: 5'h1f, data: 16'hffff};
        if (i < log_q.size()) a = log_q[i];
        return a;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural peripheral: registered read data (one cycle latency)
    always @(posedge clk) begin
        if (bus_cs && bus_wr) begin
            if (bus_addr == REG_A_ADDR) begin
                a_reg   <= bus_dout;
                started <= 1'b0;
            end else if (bus_addr == REG_INIT_ADDR && bus_dout[0]) begin
                init_cyc <= cyc;
                started  <= 1'b1;
            end
        end
        if (bus_cs && bus_rd) begin
            if (bus_addr == REG_DONE_ADDR)
                bus_din <= {31'd0, (started && done_delay >= 0 && (cyc - init_cyc) >= done_delay)};
            else if (bus_addr == REG_RESULT_ADDR)
                bus_din <= isqrt(a_reg);
            else
                bus_din <= 32'hDEAD_BEEF;
        end
    end

    // Monitor: access log, strobe sanity, response scoreboard
    always @(negedge clk) begin
        if (bus_cs) log_q.push_back('{cyc: cyc, wr: bus_wr, addr: bus_addr, data: bus_dout});
        if (bus_cs && (bus_rd == bus_wr)) proto_bad <= proto_bad + 1;
        if (!bus_cs && (bus_rd || bus_wr)) proto_bad <= proto_bad + 1;
        if (resp_valid && !prev_rv) rv_rise_cyc <= cyc;
        prev_rv <= resp_valid;
        if (resp_valid && resp_ready) begin
            resp_count <= resp_count + 1;
            if (exp_q.size() == 0) begin
                check_value("unexpected_resp", 32'd1, 32'd0);
            end else begin
                check_value("resp_result", resp_result, exp_q[0].result);
                check_value("resp_timeout", 32'(resp_timeout), 32'(exp_q[0].timeout));
                exp_q.delete(0);
            end
        end
    end

    task automatic send(input logic [15:0] op, input int delay, input bit push,
                        input logic [31:0] res, input bit to, output int t_acc);
        done_delay = delay;
        if (push) exp_q.push_back(resp_t'{result: res, timeout: to});
        req_operand = op;
        req_valid   = 1'b1;
        t_acc       = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                t_acc = cyc;
                break;
            end
        end
        check_value("req_accepted", 32'(t_acc >= 0), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        for (int i = 0; i < budget && resp_count < n; i++) @(posedge clk);
        #1;
        check_value("resp_count", 32'(resp_count), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   ini;
        int   late;
        int   rd10;
        acc_t a;

        reset = 1'b0; req_valid = 1'b0; req_operand = 16'h0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        check_value("rst_req_ready", 32'(req_ready), 32'd1);
        check_value("rst_strobes", 32'({bus_cs, bus_rd, bus_wr, resp_valid, busy, resp_timeout}), 32'd0);
        check_value("rst_result", resp_result, 32'd0);
        check_value("rst_addr_dout", {11'd0, bus_addr, bus_dout}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Cycle check: done on first poll
        log_q = {};
        send(16'h0441, 0, 1'b1, 32'h0000_0021, 1'b0, t);
        wait_resp(1, 100);
        check_value("a_nacc", 32'(log_q.size()), 32'd4);
        a = get_acc(0);
        check_value("a_wra_cyc", 32'(a.cyc), 32'(t + 1));
        check_value("a_wra", {a.wr, 10'd0, a.addr, a.data}, {1'b1, 10'd0, 5'h04, 16'h0441});
        a = get_acc(1);
        check_value("a_wrinit_cyc", 32'(a.cyc), 32'(t + 3));
        check_value("a_wrinit", {a.wr, 10'd0, a.addr, a.data}, {1'b1, 10'd0, 5'h0C, 16'h0001});
        a = get_acc(2);
        check_value("a_poll_cyc", 32'(a.cyc), 32'(t + 8));
        check_value("a_poll", {a.wr, 26'd0, a.addr}, {1'b0, 26'd0, 5'h14});
        a = get_acc(3);
        check_value("a_rdres_cyc", 32'(a.cyc), 32'(t + 11));
        check_value("a_rdres", {a.wr, 26'd0, a.addr}, {1'b0, 26'd0, 5'h10});
        check_value("a_rv_rise", 32'(rv_rise_cyc), 32'(t + 13));

        // Nominal: done 17 cycles after INIT
        log_q = {};
        send(16'h0441, 17, 1'b1, 32'h0000_0021, 1'b0, t);
        wait_resp(2, 300);
        check_value("n_nacc", 32'(log_q.size()), 32'd6);
        a = get_acc(0);
        check_value("n_wra", {a.wr, 10'd0, a.addr, a.data}, {1'b1, 10'd0, 5'h04, 16'h0441});
        a = get_acc(1);
        ini = a.cyc;
        check_value("n_wrinit", {a.wr, 10'd0, a.addr, a.data}, {1'b1, 10'd0, 5'h0C, 16'h0001});
        for (int i = 2; i < 5; i++) begin
            a = get_acc(i);
            check_value("n_poll", {a.wr, 26'd0, a.addr}, {1'b0, 26'd0, 5'h14});
        end
        check_value("n_done_poll_cyc", 32'(get_acc(4).cyc), 32'(ini + 17));
        a = get_acc(5);
        check_value("n_rdres", {a.wr, 26'd0, a.addr}, {1'b0, 26'd0, 5'h10});
        repeat (20) @(posedge clk);
        #1;
        check_value("n_single_resp", 32'(resp_count), 32'd2);

        // Timeout: DONE never set
        log_q = {};
        send(16'h0441, -1, 1'b1, 32'h0, 1'b1, t);
        wait_resp(3, 300);
        ini  = get_acc(1).cyc;
        late = 0;
        rd10 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].addr == 5'h10) rd10++;
            if (log_q[i].cyc >= rv_rise_cyc) late++;
        end
        check_value("to_no_rd_result", 32'(rd10), 32'd0);
        check_value("to_no_late_access", 32'(late), 32'd0);
        check_value("to_rv_rise", 32'(rv_rise_cyc), 32'(ini + 65));
        check_value("to_last_poll", 32'(get_acc(log_q.size() - 1).cyc), 32'(ini + 59));

        // Backpressure and ignored requests
        resp_ready = 1'b0;
        log_q = {};
        send(16'h0441, 0, 1'b1, 32'h0000_0021, 1'b0, t);
        repeat (4) begin
            req_operand = 16'hBEEF;
            req_valid   = ~req_valid;
            @(negedge clk);
            check_value("bp_req_ready_busy", 32'({req_ready, busy}), 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 100 && !resp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check_value("bp_resp_valid", 32'(resp_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check_value("bp_hold_valid", 32'({resp_valid, req_ready}), 32'd2);
            check_value("bp_hold_result", resp_result, 32'h0000_0021);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        wait_resp(4, 20);
        check_value("bp_nacc", 32'(log_q.size()), 32'd4);
        send(16'h0010, 0, 1'b1, 32'h0000_0004, 1'b0, t);
        wait_resp(5, 100);

        // Reset during WAIT_POLL
        log_q = {};
        send(16'h0441, -1, 1'b0, 32'h0, 1'b0, t);
        repeat (3) @(posedge clk);
        #2;
        check_value("mr_pre_nacc", 32'(log_q.size()), 32'd2);
        reset = 1'b0;
        #1;
        check_value("mr_strobes", 32'({bus_cs, bus_rd, bus_wr, resp_valid, busy}), 32'd0);
        check_value("mr_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_value("mr_no_stale", 32'(resp_count), 32'd5);
        check_value("mr_ready_after", 32'(req_ready), 32'd1);
        send(16'h0000, 0, 1'b1, 32'h0, 1'b0, t);
        wait_resp(6, 100);

        check_value("protocol", 32'(proto_bad), 32'd0);
        check_value("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
